lavanderia_param: RTL and testbench

Parametrised coin-operated laundry controller, next generation of the single-machine `Lavanderia` FSM. Counts coins from a level-type coin sensor and, on `finalizar_pago`, starts one of three services (`SECADO`, `LAVADO`, `LAVADO_PESADO`) according to configurable prices. It then holds the service output for a configurable duration and returns coins: a full refund on cancel or insufficient credit, and change when enabled. It sits between the coin acceptor / front-panel buttons and the machine actuators.

---
 rtl/lavanderia_param.sv | 183 ++++++++++++++++++
 tb/tb_lavanderia_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lavanderia_param.sv
// Coin-operated laundry controller: counts coins, starts SECADO/LAVADO/LAVADO_PESADO
// by price, times the service and returns coins. Define LAVANDERIA_CAMBIO_EN for change-giving.
module lavanderia_param #(
    parameter int CNT_W    = 4,
    parameter int P_SECADO = 3,
    parameter int P_LAVADO = 4,
    parameter int P_PESADO = 9,
    parameter int TIMER_W  = 8,
    parameter int T_SECADO = 8,
    parameter int T_LAVADO = 10,
    parameter int T_PESADO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intro_moneda,
    input  logic             finalizar_pago,
    input  logic             cancelar,
    output logic             SECADO,
    output logic             LAVADO,
    output logic             LAVADO_PESADO,
    output logic             insuficiente,
    output logic             devolver_moneda,
    output logic [CNT_W-1:0] credito,
    output logic             ocupado
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_COBRO      = 2'd1;
    localparam logic [1:0] S_SERVICIO   = 2'd2;
    localparam logic [1:0] S_DEVOLUCION = 2'd3;

    localparam logic [2:0] SV_NONE = 3'b000;
    localparam logic [2:0] SV_SEC  = 3'b001;
    localparam logic [2:0] SV_LAV  = 3'b010;
    localparam logic [2:0] SV_PES  = 3'b100;

    localparam logic [CNT_W-1:0] CRED_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PR_SEC   = CNT_W'(P_SECADO);
    localparam logic [CNT_W-1:0] PR_LAV   = CNT_W'(P_LAVADO);
    localparam logic [CNT_W-1:0] PR_PES   = CNT_W'(P_PESADO);

    logic [1:0]         state;
    logic               coin_p0;
    logic               edge_p1;
    logic [CNT_W-1:0]   cred;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         svc;
    logic               dev_q;
    logic               insuf_q;
    logic [CNT_W-1:0]   c_eff;
    logic [2:0]         sel;
`ifdef LAVANDERIA_CAMBIO_EN
    logic [CNT_W-1:0]   change;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && v != CRED_MAX) ? v + CNT_W'(1) : v;
    endfunction

    // Equal prices resolve toward the heavier service (later test wins ties).
    function automatic logic [2:0] pick_svc(input logic [CNT_W-1:0] c);
        logic [2:0] s;
`ifdef LAVANDERIA_CAMBIO_EN
        logic [CNT_W-1:0] best;
        s    = SV_NONE;
        best = '0;
        if (PR_SEC <= c) begin s = SV_SEC; best = PR_SEC; end
        if (PR_LAV <= c && (s == SV_NONE || PR_LAV >= best)) begin s = SV_LAV; best = PR_LAV; end
        if (PR_PES <= c && (s == SV_NONE || PR_PES >= best)) begin s = SV_PES; best = PR_PES; end
`else
        if (c == PR_PES)      s = SV_PES;
        else if (c == PR_LAV) s = SV_LAV;
        else if (c == PR_SEC) s = SV_SEC;
        else                  s = SV_NONE;
`endif
        return s;
    endfunction

`ifdef LAVANDERIA_CAMBIO_EN
    function automatic logic [CNT_W-1:0] price_of(input logic [2:0] s);
        return s[2] ? PR_PES : (s[1] ? PR_LAV : PR_SEC);
    endfunction
`endif

    function automatic logic [TIMER_W-1:0] time_of(input logic [2:0] s);
        return s[2] ? TIMER_W'(T_PESADO) : (s[1] ? TIMER_W'(T_LAVADO) : TIMER_W'(T_SECADO));
    endfunction

    assign c_eff = sat_inc(cred, edge_p1);
    assign sel   = pick_svc(c_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            coin_p0 <= 1'b1;
            edge_p1 <= 1'b0;
            cred    <= '0;
            timer   <= '0;
            svc     <= SV_NONE;
            dev_q   <= 1'b0;
            insuf_q <= 1'b0;
`ifdef LAVANDERIA_CAMBIO_EN
            change  <= '0;
`endif
        end else begin
            // stage p0 -> p1: sensor sample and rising-edge detect
            coin_p0 <= intro_moneda;
            edge_p1 <= intro_moneda & ~coin_p0;
            insuf_q <= 1'b0;
            // stage p1 -> state: edge applied to credit, FSM step
            case (state)
                S_IDLE: begin
                    dev_q <= 1'b0;
                    if (edge_p1) begin
                        cred  <= c_eff;
                        state <= S_COBRO;
                    end
                end
                S_COBRO: begin
                    if (cancelar) begin
                        cred  <= c_eff;
                        dev_q <= 1'b1;
                        state <= S_DEVOLUCION;
                    end else if (finalizar_pago) begin
                        if (sel != SV_NONE) begin
                            svc    <= sel;
                            timer  <= time_of(sel);
                            cred   <= '0;
`ifdef LAVANDERIA_CAMBIO_EN
                            change <= c_eff - price_of(sel);
`endif
                            state  <= S_SERVICIO;
                        end else begin
                            insuf_q <= 1'b1;
                            cred    <= c_eff;
                            dev_q   <= 1'b1;
                            state   <= S_DEVOLUCION;
                        end
                    end else begin
                        cred <= c_eff;
                    end
                end
                S_SERVICIO: begin
                    timer <= timer - TIMER_W'(1);
                    if (timer <= TIMER_W'(1)) begin
                        svc <= SV_NONE;
`ifdef LAVANDERIA_CAMBIO_EN
                        if (change != '0) begin
                            cred  <= change;
                            dev_q <= 1'b1;
                            state <= S_DEVOLUCION;
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
                S_DEVOLUCION: begin
                    if (dev_q) begin
                        dev_q <= 1'b0;
                        cred  <= cred - CNT_W'(1);
                        if (cred <= CNT_W'(1))
                            state <= S_IDLE;
                    end else begin
                        dev_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign SECADO          = svc[0];
    assign LAVADO          = svc[1];
    assign LAVADO_PESADO   = svc[2];
    assign insuficiente    = insuf_q;
    assign devolver_moneda = dev_q;
    assign credito         = cred;
    assign ocupado         = (state == S_SERVICIO) || (state == S_DEVOLUCION);

endmodule

// File: tb/tb_lavanderia_param.sv
// Directed bench for lavanderia_param with default parameters; follows LAVANDERIA_CAMBIO_EN
// for the 5-coin case.
module tb_lavanderia_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       intro_moneda;
    logic       finalizar_pago;
    logic       cancelar;
    logic       SECADO;
    logic       LAVADO;
    logic       LAVADO_PESADO;
    logic       insuficiente;
    logic       devolver_moneda;
    logic [3:0] credito;
    logic       ocupado;

    int n_chk  = 0;
    int n_pass = 0;
    int sec_n, lav_n, pes_n, ins_n, dev_n, ocu_n;
    logic [2:0] dev_first;

    always #5 clk = ~clk;

    lavanderia_param dut (
        .clk            (clk),
        .rst            (rst),
        .intro_moneda   (intro_moneda),
        .finalizar_pago (finalizar_pago),
        .cancelar       (cancelar),
        .SECADO         (SECADO),
        .LAVADO         (LAVADO),
        .LAVADO_PESADO  (LAVADO_PESADO),
        .insuficiente   (insuficiente),
        .devolver_moneda(devolver_moneda),
        .credito        (credito),
        .ocupado        (ocupado)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin();
        intro_moneda = 1'b1;
        tick();
        intro_moneda = 1'b0;
        tick();
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) coin();
    endtask

    task automatic pulse_fin();
        finalizar_pago = 1'b1;
        tick();
        finalizar_pago = 1'b0;
    endtask

    // Counts high cycles of every output over n samples, starting with the current one.
    task automatic watch(input int n);
        sec_n = 0; lav_n = 0; pes_n = 0; ins_n = 0; dev_n = 0; ocu_n = 0;
        dev_first = '0;
        for (int i = 0; i < n; i++) begin
            sec_n += int'(SECADO);
            lav_n += int'(LAVADO);
            pes_n += int'(LAVADO_PESADO);
            ins_n += int'(insuficiente);
            dev_n += int'(devolver_moneda);
            ocu_n += int'(ocupado);
            if (i < 3) dev_first[i] = devolver_moneda;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; intro_moneda = 1'b0; finalizar_pago = 1'b0; cancelar = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_credito", int'(credito), 0);
        chk("rst_outs", int'({SECADO, LAVADO, LAVADO_PESADO, insuficiente, devolver_moneda, ocupado}), 0);
        tick(); tick();

        // 3 coins -> SECADO, 8 cycles
        coins(3);
        chk("sec_credito", int'(credito), 3);
        pulse_fin();
        chk("sec_first", int'(SECADO), 1);
        chk("sec_cred_zero", int'(credito), 0);
        watch(30);
        chk("sec_len", sec_n, 8);
        chk("sec_dev", dev_n, 0);
        chk("sec_others", lav_n + pes_n + ins_n, 0);
        chk("sec_end_cred", int'(credito), 0);
        chk("sec_end_ocu", int'(ocupado), 0);

        // 9 coins -> LAVADO_PESADO, 16 cycles
        coins(9);
        pulse_fin();
        watch(30);
        chk("pes_len", pes_n, 16);
        chk("pes_ocu", ocu_n, 16);
        chk("pes_dev", dev_n, 0);

        // 5 coins: rejected exact payment, or LAVADO with 1 coin change
        coins(5);
        pulse_fin();
        chk("c5_credito", int'(credito), `ifdef LAVANDERIA_CAMBIO_EN 0 `else 5 `endif);
        watch(30);
`ifdef LAVANDERIA_CAMBIO_EN
        chk("c5_lav", lav_n, 10);
        chk("c5_dev", dev_n, 1);
        chk("c5_ins", ins_n, 0);
        chk("c5_ocu", ocu_n, 11);
`else
        chk("c5_ins", ins_n, 1);
        chk("c5_dev", dev_n, 5);
        chk("c5_spacing", int'(dev_first), 5);
        chk("c5_svc", sec_n + lav_n + pes_n, 0);
        chk("c5_ocu", ocu_n, 9);
`endif

        // cancel and finalize together: cancel wins
        coins(2);
        cancelar = 1'b1; finalizar_pago = 1'b1;
        tick();
        cancelar = 1'b0; finalizar_pago = 1'b0;
        watch(10);
        chk("can_dev", dev_n, 2);
        chk("can_ins", ins_n, 0);
        chk("can_svc", sec_n + lav_n + pes_n, 0);
        chk("can_ocu", ocu_n, 3);

        // saturation at 15
        coins(17);
        chk("sat_credito", int'(credito), 15);
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        watch(34);
        chk("sat_dev", dev_n, 15);
        chk("sat_ocu", ocu_n, 29);

        // coins during service are ignored
        coins(9);
        pulse_fin();
        coins(3);
        chk("svc_coin_cred", int'(credito), 0);
        chk("svc_coin_pes", int'(LAVADO_PESADO), 1);
        watch(20);
        chk("svc_coin_rest", pes_n, 10);
        chk("svc_coin_end_cred", int'(credito), 0);
        chk("svc_coin_end_ocu", int'(ocupado), 0);

        // reset in the middle of LAVADO with the sensor held high
        coins(4);
        pulse_fin();
        tick(); tick(); tick();
        chk("mid_lav", int'(LAVADO), 1);
        rst = 1'b1; intro_moneda = 1'b1;
        tick();
        chk("mid_rst_outs", int'({SECADO, LAVADO, LAVADO_PESADO, insuficiente, devolver_moneda, ocupado}), 0);
        chk("mid_rst_cred", int'(credito), 0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("held_sensor_cred", int'(credito), 0);
        chk("held_sensor_ocu", int'(ocupado), 0);
        intro_moneda = 1'b0;
        tick();
        coin();
        chk("after_rst_coin", int'(credito), 1);
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        watch(6);
        chk("after_rst_dev", dev_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
